// File: rtl/dnn_fxp_pkg.sv
// -----------------------------------------------------------------------------
// dnn_fxp_pkg
// Shared fixed-point helpers for the DNN datapath blocks.
//   - state_t      : control states of the serial delta stage
//   - frac_bits()  : fraction bits of a signed word (width - int_bits - 1)
//   - fxp_max()    : largest representable value of a signed word of 'width'
//   - fxp_min()    : smallest representable value of a signed word of 'width'
// The min/max helpers return a 64-bit value, so product words up to 64 bits
// (i.e. operand widths up to 32 bits) can be compared against them.
// -----------------------------------------------------------------------------
package dnn_fxp_pkg;

  localparam int DEF_WIDTH    = 12;
  localparam int DEF_INT_BITS = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int frac_bits(input int width, input int int_bits);
    return width - int_bits - 1;
  endfunction

  function automatic longint fxp_max(input int width);
    return (longint'(1) <<< (width - 1)) - longint'(1);
  endfunction

  function automatic longint fxp_min(input int width);
    return -(longint'(1) <<< (width - 1));
  endfunction

endpackage

// File: rtl/fxp_mul_sat.sv
// -----------------------------------------------------------------------------
// fxp_mul_sat
// Combinational signed fixed-point multiply with saturation.
//   y = sat( (a * b) >>> F )
// The shift is arithmetic, so the result truncates toward -inf (no rounding).
// Ports:
//   i_a, i_b : signed W-bit operands, F fraction bits each
//   o_y      : signed W-bit result, F fraction bits
//   o_sat    : high when the result was clamped to max/min
// -----------------------------------------------------------------------------
module fxp_mul_sat
  import dnn_fxp_pkg::*;
#(
  parameter int W = DEF_WIDTH,
  parameter int F = frac_bits(DEF_WIDTH, DEF_INT_BITS)
) (
  input  logic signed [W-1:0] i_a,
  input  logic signed [W-1:0] i_b,
  output logic signed [W-1:0] o_y,
  output logic                o_sat
);

  localparam int PW = 2 * W;

  localparam longint MAX_L = fxp_max(W);
  localparam longint MIN_L = fxp_min(W);

  // Limits expressed at product width so the comparison stays fully signed.
  localparam logic signed [PW-1:0] Q_MAX = PW'(MAX_L);
  localparam logic signed [PW-1:0] Q_MIN = PW'(MIN_L);

  logic signed [PW-1:0] w_a_ext;
  logic signed [PW-1:0] w_b_ext;
  logic signed [PW-1:0] w_p;
  logic signed [PW-1:0] w_q;

  // Explicit sign extension keeps the full 2W-bit product exact.
  assign w_a_ext = {{W{i_a[W-1]}}, i_a};
  assign w_b_ext = {{W{i_b[W-1]}}, i_b};
  assign w_p     = w_a_ext * w_b_ext;
  assign w_q     = w_p >>> F;

  always_comb begin
    o_y   = w_q[W-1:0];
    o_sat = 1'b0;
    if (w_q > Q_MAX) begin
      o_y   = Q_MAX[W-1:0];
      o_sat = 1'b1;
    end else if (w_q < Q_MIN) begin
      o_y   = Q_MIN[W-1:0];
      o_sat = 1'b1;
    end
  end

endmodule

// File: rtl/delta_out_serial.sv
// -----------------------------------------------------------------------------
// delta_out_serial
// Output-layer delta stage: d[i] = c[i] * sp[i] (signed fixed point, saturating)
// computed with a single shared multiplier, one element per cycle.
// Ports:
//   clk, reset          : clock (rising edge) and asynchronous active-high reset
//   in_valid / in_ready : input handshake for the c/sp vectors
//   c[z], sp[z]         : cost terms and sigmoid-derivative values
//   out_valid/out_ready : output handshake for the delta vector
//   d[z]                : registered output deltas
//   sat                 : some element of the current d was clamped
// Timing: out_valid rises z cycles after the accept edge. From DONE a new
// vector can be accepted on the release edge, giving one vector per z+1 cycles.
// -----------------------------------------------------------------------------
module delta_out_serial
  import dnn_fxp_pkg::*;
#(
  parameter int z        = 4,
  parameter int width    = DEF_WIDTH,
  parameter int int_bits = DEF_INT_BITS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [width-1:0] c  [z],
  input  logic signed [width-1:0] sp [z],
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [width-1:0] d  [z],
  output logic                    sat
);

  localparam int F    = frac_bits(width, int_bits);
  localparam int IDXW = (z > 1) ? $clog2(z) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(z - 1);

  state_t                  r_state;
  logic [IDXW-1:0]         r_idx;
  logic signed [width-1:0] r_c  [z];
  logic signed [width-1:0] r_sp [z];
  logic signed [width-1:0] r_d  [z];
  logic                    r_sat;

  logic signed [width-1:0] w_c_sel;
  logic signed [width-1:0] w_sp_sel;
  logic signed [width-1:0] w_y;
  logic                    w_sat;
  logic                    w_accept;

  // A new vector may enter from IDLE, or from DONE on the same edge the
  // consumer takes the current result.
  assign in_ready  = (r_state == ST_IDLE) | ((r_state == ST_DONE) & out_ready);
  assign out_valid = (r_state == ST_DONE);
  assign sat       = r_sat;
  assign w_accept  = in_valid & in_ready;

  assign w_c_sel  = r_c[r_idx];
  assign w_sp_sel = r_sp[r_idx];

  fxp_mul_sat #(
    .W (width),
    .F (F)
  ) u_mul (
    .i_a   (w_c_sel),
    .i_b   (w_sp_sel),
    .o_y   (w_y),
    .o_sat (w_sat)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_sat   <= 1'b0;
      for (int i = 0; i < z; i++) begin
        r_c[i]  <= '0;
        r_sp[i] <= '0;
        r_d[i]  <= '0;
      end
    end else if (w_accept) begin
      // Only reachable from IDLE or DONE; inputs are snapshotted here so later
      // port activity cannot disturb the pass.
      for (int i = 0; i < z; i++) begin
        r_c[i]  <= c[i];
        r_sp[i] <= sp[i];
      end
      r_idx   <= '0;
      r_sat   <= 1'b0;
      r_state <= ST_CALC;
    end else begin
      case (r_state)
        ST_CALC: begin
          r_d[r_idx] <= w_y;
          if (w_sat) begin
            r_sat <= 1'b1;
          end
          if (r_idx == IDX_LAST) begin
            r_idx   <= '0;
            r_state <= ST_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_DONE: begin
          // Without a new vector, release drops out_valid; d is left as is.
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          // IDLE without an accept: nothing changes.
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < z; gi++) begin : g_dout
    assign d[gi] = r_d[gi];
  end

endmodule

// File: tb/tb_delta_out_serial.sv
// -----------------------------------------------------------------------------
// tb_delta_out_serial
// Directed test of delta_out_serial (z=4, width=12, int_bits=3) with
// hand-computed expected deltas.
// -----------------------------------------------------------------------------
module tb_delta_out_serial;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic signed [11:0] c  [4];
  logic signed [11:0] sp [4];
  logic              out_valid;
  logic              out_ready;
  logic signed [11:0] d  [4];
  logic              sat;

  logic [11:0] tv_c  [4];
  logic [11:0] tv_sp [4];
  logic [11:0] exp_d [4];

  int n_checks = 0;
  int n_errors = 0;

  delta_out_serial #(
    .z        (4),
    .width    (12),
    .int_bits (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .c         (c),
    .sp        (sp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .sat       (sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Vectors are packed index 3..0, 12 bits per element.
  task automatic load_tv(input logic [47:0] cv, input logic [47:0] spv, input logic [47:0] ev);
    for (int i = 0; i < 4; i++) begin
      tv_c[i]  = cv[i*12 +: 12];
      tv_sp[i] = spv[i*12 +: 12];
      exp_d[i] = ev[i*12 +: 12];
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < 4; i++) begin
      c[i]  = tv_c[i];
      sp[i] = tv_sp[i];
    end
  endtask

  task automatic scramble_inputs();
    for (int i = 0; i < 4; i++) begin
      c[i]  = 12'($urandom);
      sp[i] = 12'($urandom);
    end
  endtask

  task automatic wait_out(input string name, input int exp_lat, input bit scramble);
    int lat;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      if (scramble) scramble_inputs();
      @(posedge clk);
      #1;
      lat++;
    end
    chk({name, "_latency"}, lat, exp_lat);
  endtask

  task automatic check_out(input string name, input logic exp_sat);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_d%0d", name, i), $unsigned(d[i]), exp_d[i]);
    end
    chk({name, "_sat"}, sat, exp_sat);
    $display("vector %s: d0=%h d1=%h d2=%h d3=%h sat=%b", name, d[0], d[1], d[2], d[3], sat);
  endtask

  // Accept a vector from IDLE, wait for out_valid and check the result.
  task automatic run_vec(input string name, input logic exp_sat, input bit scramble);
    chk({name, "_in_ready"}, in_ready, 1'b1);
    drive_inputs();
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (scramble) scramble_inputs();
    wait_out(name, 4, scramble);
    check_out(name, exp_sat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      c[i]  = '0;
      sp[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_sat", sat, 1'b0);
    chk("rst_d0", $unsigned(d[0]), 12'h000);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Basic vector
    load_tv({12'h000, 12'hff0, 12'h040, 12'hf00},
            {12'h040, 12'h040, 12'h040, 12'h040},
            {12'h000, 12'hffc, 12'h010, 12'hfc0});
    run_vec("basic", 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("idle_out_valid", out_valid, 1'b0);
    chk("idle_d_hold", $unsigned(d[1]), 12'h010);

    // Saturation
    load_tv({12'h800, 12'h100, 12'h800, 12'h7ff},
            {12'h800, 12'h100, 12'h7ff, 12'h7ff},
            {12'h7ff, 12'h100, 12'h800, 12'h7ff});
    run_vec("satur", 1'b1, 1'b0);
    @(posedge clk);
    #1;

    // Truncation toward -inf; sat must clear after the saturating vector
    load_tv({12'hffd, 12'h003, 12'hfff, 12'h001},
            {12'h080, 12'h080, 12'h080, 12'h080},
            {12'hffe, 12'h001, 12'hfff, 12'h000});
    run_vec("trunc", 1'b0, 1'b0);
    @(posedge clk);
    #1;

    // Input isolation: ports scrambled every cycle after accept
    load_tv({12'h100, 12'h200, 12'hf00, 12'h080},
            {12'h100, 12'h040, 12'h100, 12'h200},
            {12'h100, 12'h080, 12'hf00, 12'h100});
    run_vec("isolate", 1'b0, 1'b1);
    @(posedge clk);
    #1;

    // Back-pressure: hold DONE for 10 cycles
    out_ready = 1'b0;
    load_tv({12'h000, 12'hff0, 12'h040, 12'hf00},
            {12'h040, 12'h040, 12'h040, 12'h040},
            {12'h000, 12'hffc, 12'h010, 12'hfc0});
    run_vec("bp", 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_sat", sat, 1'b0);
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("bp_hold_d%0d", i), $unsigned(d[i]), exp_d[i]);
      end
    end

    // Back-to-back: release and accept on the same edge
    load_tv({12'h800, 12'h100, 12'h800, 12'h7ff},
            {12'h800, 12'h100, 12'h7ff, 12'h7ff},
            {12'h7ff, 12'h100, 12'h800, 12'h7ff});
    drive_inputs();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("b2b_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("b2b_busy", out_valid, 1'b0);
    wait_out("b2b", 4, 1'b0);
    check_out("b2b", 1'b1);
    @(posedge clk);
    #1;

    // Reset in the middle of CALC (idx == 2)
    load_tv({12'h000, 12'hff0, 12'h040, 12'hf00},
            {12'h040, 12'h040, 12'h040, 12'h040},
            {12'h000, 12'hffc, 12'h010, 12'hfc0});
    chk("mid_in_ready", in_ready, 1'b1);
    drive_inputs();
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    chk("mid_rst_sat", sat, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("mid_rst_d%0d", i), $unsigned(d[i]), 12'h000);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    run_vec("after_rst", 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
